// File: rtl/axis_rf_write_decoder.sv
// ----------------------------------------------------------------------------
// axis_rf_write_decoder
//
// Purpose:
//   Endpoint-side decoder for the register-file weight-load protocol inside an
//   MVM tile. AXI-Stream weight-write packets arriving from the NoC are checked
//   against this node's destination ID and a one-hot register-file select.
//   Each accepted beat of a good packet becomes one register-file write
//   command. Continuation beats form an address-incrementing burst.
//   Packets with a bad header are discarded up to and including TLAST, and
//   each one is counted in a saturating error counter.
//
// Ports:
//   i_clk              single clock
//   i_rst_n            synchronous, active-low reset
//   i_axis_s_tvalid    stream beat valid
//   o_axis_s_tready    stream beat accepted when tvalid && tready
//   i_axis_s_tdata     [31:0] data, [40:32] address, [40+NUM_RF:41] RF select
//   i_axis_s_tdest     destination ID, checked on the header beat only
//   i_axis_s_tlast     last beat of the packet
//   o_rf_wr_valid      write command valid
//   i_rf_wr_ready      register-file bank accepts the command
//   o_rf_wr_sel        one-hot register-file select
//   o_rf_wr_addr       register-file word address
//   o_rf_wr_data       register-file write data
//   o_wr_count         number of commands handed to the bank (wraps)
//   o_err_count        number of dropped packets (saturates at 16'hFFFF)
//
// TDATAW must be at least 41+NUM_RF so that the select field fits in TDATA.
// ----------------------------------------------------------------------------
module axis_rf_write_decoder #(
    parameter int               TDATAW  = 128,
    parameter int               DESTW   = 12,
    parameter int               NUM_RF  = 64,
    parameter int               ADDRW   = 9,
    parameter logic [DESTW-1:0] MY_DEST = 'h002
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_axis_s_tvalid,
    output logic              o_axis_s_tready,
    input  logic [TDATAW-1:0] i_axis_s_tdata,
    input  logic [DESTW-1:0]  i_axis_s_tdest,
    input  logic              i_axis_s_tlast,
    output logic              o_rf_wr_valid,
    input  logic              i_rf_wr_ready,
    output logic [NUM_RF-1:0] o_rf_wr_sel,
    output logic [ADDRW-1:0]  o_rf_wr_addr,
    output logic [31:0]       o_rf_wr_data,
    output logic [31:0]       o_wr_count,
    output logic [15:0]       o_err_count
);

    localparam logic [1:0] ST_HDR   = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    logic [1:0]        r_state;
    logic              r_valid;
    logic [NUM_RF-1:0] r_sel;
    logic [ADDRW-1:0]  r_addr;
    logic [31:0]       r_data;
    logic [31:0]       r_wr_count;
    logic [15:0]       r_err_count;

    logic              w_tready;
    logic              w_beat;
    logic [NUM_RF-1:0] w_sel_field;
    logic [ADDRW-1:0]  w_addr_field;
    logic              w_hdr_ok;
    logic              w_hdr_load;
    logic              w_burst_load;
    logic              w_hdr_err;

    // Bits of TDATA above the select field carry nothing for this endpoint.
    generate
        if (TDATAW > 41 + NUM_RF) begin : g_spare_tdata
            logic w_unused_tdata;
            assign w_unused_tdata = ^i_axis_s_tdata[TDATAW-1:41+NUM_RF];
        end
    endgenerate

    // DROP never stalls, so a bad packet drains even while the bank is busy.
    // Otherwise a beat is taken only if the output buffer is empty or is
    // being emptied on this same edge.
    assign w_tready = i_rst_n && ((r_state == ST_DROP) || !r_valid || i_rf_wr_ready);
    assign w_beat   = i_axis_s_tvalid && w_tready;

    assign w_sel_field  = i_axis_s_tdata[41 +: NUM_RF];
    assign w_addr_field = i_axis_s_tdata[32 +: ADDRW];
    assign w_hdr_ok     = (i_axis_s_tdest == MY_DEST) && $onehot(w_sel_field);

    assign w_hdr_load   = w_beat && (r_state == ST_HDR) && w_hdr_ok;
    assign w_burst_load = w_beat && (r_state == ST_BURST);
    assign w_hdr_err    = w_beat && (r_state == ST_HDR) && !w_hdr_ok;

    // Packet-level state. A single-beat packet, good or bad, leaves the
    // decoder waiting for the next header.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_HDR;
        end else begin
            case (r_state)
                ST_HDR: begin
                    if (w_beat && !i_axis_s_tlast) begin
                        r_state <= w_hdr_ok ? ST_BURST : ST_DROP;
                    end
                end
                ST_BURST, ST_DROP: begin
                    if (w_beat && i_axis_s_tlast) begin
                        r_state <= ST_HDR;
                    end
                end
                default: r_state <= ST_HDR;
            endcase
        end
    end

    // Single-entry command buffer. Its sel/addr registers also act as the
    // burst latch: a continuation beat reuses the held select and steps the
    // held address, which wraps naturally at the top of the address space.
    // A load on the same edge as a drain replaces the old command, so valid
    // stays high.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_sel   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (w_hdr_load) begin
            r_valid <= 1'b1;
            r_sel   <= w_sel_field;
            r_addr  <= w_addr_field;
            r_data  <= i_axis_s_tdata[31:0];
        end else if (w_burst_load) begin
            r_valid <= 1'b1;
            r_addr  <= r_addr + ADDRW'(1);
            r_data  <= i_axis_s_tdata[31:0];
        end else if (i_rf_wr_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Commands count when the bank takes them. Errors count once per
    // rejected header and stick at all-ones.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_count  <= '0;
            r_err_count <= '0;
        end else begin
            if (r_valid && i_rf_wr_ready) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
            if (w_hdr_err && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign o_axis_s_tready = w_tready;
    assign o_rf_wr_valid   = r_valid;
    assign o_rf_wr_sel     = r_sel;
    assign o_rf_wr_addr    = r_addr;
    assign o_rf_wr_data    = r_data;
    assign o_wr_count      = r_wr_count;
    assign o_err_count     = r_err_count;

endmodule
